// File: rtl/frame_loader_pkg.sv
// frame_loader_pkg: shared constants, state encoding and header validation
// for the frame configuration loader.
//   SYNC_BYTE        marker expected in the top byte of every header
//   *_LSB            bit positions of the header fields
//   state_t          loader FSM states
//   header_ok()      accepts a header word against the column/frame limits
package frame_loader_pkg;
    localparam logic [7:0] SYNC_BYTE = 8'hFA;
    localparam int SYNC_LSB  = 24;
    localparam int COL_LSB   = 16;
    localparam int START_LSB = 8;
    localparam int COUNT_LSB = 0;
    typedef enum logic [2:0] {IDLE, LOAD, STROBE, HOLD, CHECK} state_t;
    // S+N is formed with a spare bit so a large start plus count cannot wrap
    // back into range.
    function automatic logic header_ok(input logic [31:0] w, input int num_cols, input int max_frames);
        logic [7:0] col, s, n;
        col = w[COL_LSB +: 8];
        s   = w[START_LSB +: 8];
        n   = w[COUNT_LSB +: 8];
        return w[SYNC_LSB +: 8] == SYNC_BYTE && int'(col) < num_cols && n != 8'd0
            && int'({1'b0, s} + {1'b0, n}) <= max_frames;
    endfunction
endpackage

// File: rtl/frame_config_loader_onehot_dec.sv
// onehot_dec: binary index to one-hot vector, all zeros when disabled.
//   idx  binary index (must be < W when en is high)
//   en   output enable
//   y    one-hot result
module onehot_dec #(
    parameter int W  = 4,
    parameter int IW = 2
) (
    input  logic [IW-1:0] idx,
    input  logic          en,
    output logic [W-1:0]  y
);
    assign y = en ? W'(1) << idx : '0;
endmodule

// File: rtl/frame_config_loader.sv
// frame_config_loader: turns a header + N word stream into column-select and
// frame-strobe pulses for frame-based configuration latches.
//   UserCLK, reset          clock, synchronous active-high reset
//   s_data/s_valid/s_ready  32-bit input stream
//   FrameData               word presented to the column latches
//   ColSelect               one-hot target column
//   FrameStrobe             one-hot latch-enable pulse
//   busy / done / err       status: not idle, block complete pulse, sticky error
// Build option FRAME_LOADER_CHECKSUM_EN adds a trailer word holding the XOR of
// the header and all data words, checked in the CHECK state.
module frame_config_loader
    import frame_loader_pkg::*;
#(
    parameter int FRAME_BITS = 32,
    parameter int MAX_FRAMES = 20,
    parameter int NUM_COLS   = 16
) (
    input  logic                  UserCLK,
    input  logic                  reset,
    input  logic [31:0]           s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [FRAME_BITS-1:0] FrameData,
    output logic [NUM_COLS-1:0]   ColSelect,
    output logic [MAX_FRAMES-1:0] FrameStrobe,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int CW = $clog2(NUM_COLS);
    localparam int FW = $clog2(MAX_FRAMES);
    state_t state, next;
    logic [CW-1:0] col;
    logic [FW-1:0] cur;
    logic [7:0] remaining;
    logic hdr_ok, col_en, stb_en;
`ifdef FRAME_LOADER_CHECKSUM_EN
    logic [31:0] csum;
`endif
    assign hdr_ok = header_ok(s_data, NUM_COLS, MAX_FRAMES);

    always_ff @(posedge UserCLK) begin
        if (reset) state <= IDLE;
        else       state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = s_valid && hdr_ok ? LOAD : IDLE;
            LOAD:    next = s_valid ? STROBE : LOAD;
            STROBE:  next = HOLD;
`ifdef FRAME_LOADER_CHECKSUM_EN
            HOLD:    next = remaining == 8'd1 ? CHECK : LOAD;
`else
            HOLD:    next = remaining == 8'd1 ? IDLE : LOAD;
`endif
            CHECK:   next = s_valid ? IDLE : CHECK;
            default: next = IDLE;
        endcase
    end

    // Strobe/hold cycles refuse input so the latched word stays stable
    // around the latch-enable pulse.
    always_comb begin
        s_ready = state == IDLE || state == LOAD || state == CHECK;
        busy    = state != IDLE;
        col_en  = state == LOAD || state == STROBE || state == HOLD;
        stb_en  = state == STROBE;
    end

    always_ff @(posedge UserCLK) begin
        if (reset) begin
            col       <= '0;
            cur       <= '0;
            remaining <= '0;
            FrameData <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (state == IDLE && s_valid) begin
                if (hdr_ok) begin
                    col       <= CW'(s_data[COL_LSB +: 8]);
                    cur       <= FW'(s_data[START_LSB +: 8]);
                    remaining <= s_data[COUNT_LSB +: 8];
                    err       <= 1'b0;
`ifdef FRAME_LOADER_CHECKSUM_EN
                    csum      <= s_data;
`endif
                end else begin
                    err <= 1'b1;
                end
            end
            if (state == LOAD && s_valid) begin
                FrameData <= FRAME_BITS'(s_data);
`ifdef FRAME_LOADER_CHECKSUM_EN
                csum      <= csum ^ s_data;
`endif
            end
            if (state == HOLD) begin
                cur       <= cur + 1'b1;
                remaining <= remaining - 8'd1;
`ifndef FRAME_LOADER_CHECKSUM_EN
                done      <= remaining == 8'd1;
`endif
            end
`ifdef FRAME_LOADER_CHECKSUM_EN
            if (state == CHECK && s_valid) begin
                done <= 1'b1;
                err  <= s_data != csum;
            end
`endif
        end
    end

    onehot_dec #(.W(NUM_COLS), .IW(CW)) u_col_dec (
        .idx (col),
        .en  (col_en),
        .y   (ColSelect)
    );

    onehot_dec #(.W(MAX_FRAMES), .IW(FW)) u_stb_dec (
        .idx (cur),
        .en  (stb_en),
        .y   (FrameStrobe)
    );
endmodule

// File: tb/tb_frame_config_loader.sv
// tb_frame_config_loader: randomized self-checking bench for frame_config_loader.
module tb_frame_config_loader;
    logic        UserCLK = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready, busy, done, err;
    logic [31:0] FrameData;
    logic [15:0] ColSelect;
    logic [19:0] FrameStrobe;

`ifdef FRAME_LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] col;
        logic [19:0] stb;
        logic [31:0] data;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  checks = 0, errors = 0;
    int  done_cnt = 0, hold_bad = 0, onehot_bad = 0, done_col_bad = 0;
    bit  prev_stb = 1'b0, rst_edge = 1'b1;
    logic [31:0] prev_data = '0;

    frame_config_loader dut (
        .UserCLK     (UserCLK),
        .reset       (reset),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .FrameData   (FrameData),
        .ColSelect   (ColSelect),
        .FrameStrobe (FrameStrobe),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 UserCLK = ~UserCLK;

    always @(posedge UserCLK) rst_edge <= reset;

    // Observer: logs every strobe and watches the strobe/hold protocol.
    always @(negedge UserCLK) begin
        if (FrameStrobe != '0) begin
            obs_q.push_back('{ColSelect, FrameStrobe, FrameData});
            if ($countones(FrameStrobe) != 1 || s_ready) onehot_bad++;
        end
        if (prev_stb && !rst_edge && (FrameData !== prev_data || FrameStrobe != '0 || s_ready)) hold_bad++;
        if (done) begin
            done_cnt++;
            if (ColSelect != '0) done_col_bad++;
        end
        prev_stb  = FrameStrobe != '0;
        prev_data = FrameData;
    end

    task automatic clear_q();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic send(input logic [31:0] w, input int gap);
        int t = 0;
        repeat (gap) @(negedge UserCLK);
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && t < 100) begin
            @(negedge UserCLK);
            t++;
        end
        if (t == 100) begin
            errors++;
            $display("FAIL send_timeout: s_ready=%b, required 1", s_ready);
        end
        @(negedge UserCLK);
        s_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 100) begin
            @(negedge UserCLK);
            t++;
        end
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
        @(negedge UserCLK);
    endtask

    // Reference model for one accepted block: frame k of the block lands in
    // column c at frame S+k with the k-th data word.
    task automatic run_block(input logic [31:0] hdr, input int gap, input bit good_trailer);
        logic [31:0] w;
        logic [31:0] x;
        int c = int'(hdr[23:16]);
        int s = int'(hdr[15:8]);
        int n = int'(hdr[7:0]);
        x = hdr;
        send(hdr, gap);
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            x ^= w;
            exp_q.push_back('{16'(1) << c, 20'(1) << (s + i), w});
            send(w, gap);
        end
        if (CSUM) send(good_trailer ? x : ~x, gap);
        wait_idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge UserCLK);
        checks++;
        if ({s_ready, busy, done, err, ColSelect, FrameStrobe, FrameData} !== {1'b1, 3'b0, 68'b0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b busy=%b done=%b err=%b col=%h stb=%h data=%h, required rdy=1 rest 0",
                     s_ready, busy, done, err, ColSelect, FrameStrobe, FrameData);
        end
        reset = 1'b0;
        @(negedge UserCLK);
    endtask

    task automatic test_basic();
        int d0 = done_cnt;
        clear_q();
        run_block(32'hFA02_0003, 0, 1'b1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            errors++;
            $display("FAIL basic_done: got %0d pulses, required 1", done_cnt - d0);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: got %b, required 0", err);
        end
    endtask

    task automatic test_bad_headers();
        logic [31:0] bad [3] = '{32'hFB00_0001, 32'hFA11_0001, 32'hFA00_1305};
        clear_q();
        foreach (bad[i]) begin
            send(bad[i], 1);
            checks++;
            if ({err, busy} !== 2'b10) begin
                errors++;
                $display("FAIL bad_hdr%0d: err=%b busy=%b, required err=1 busy=0", i, err, busy);
            end
        end
        repeat (3) @(negedge UserCLK);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL bad_hdr_strobes: got %0d strobes, required 0", obs_q.size());
        end
        run_block(32'hFA00_0001, 0, 1'b1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL bad_hdr_clear: err=%b, required 0", err);
        end
    endtask

    task automatic test_boundary();
        clear_q();
        run_block(32'hFA00_1301, 0, 1'b1);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0] || obs_q[0].stb !== 20'h80000) begin
            errors++;
            $display("FAIL boundary: got %0d strobes first=%h, required 1 strobe %h", obs_q.size(),
                     obs_q.size() > 0 ? obs_q[0] : ev_t'(0), exp_q[0]);
        end
    endtask

    task automatic test_gaps();
        clear_q();
        run_block(32'hFA05_0204, 5, 1'b1);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL gaps_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL gaps_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] w;
        clear_q();
        send(32'hFA03_0004, 0);
        for (int i = 0; i < 2; i++) begin
            w = $urandom;
            exp_q.push_back('{16'h0008, 20'(1) << i, w});
            send(w, 0);
        end
        reset = 1'b1;
        @(negedge UserCLK);
        checks++;
        if ({s_ready, busy, done, err, ColSelect, FrameStrobe, FrameData} !== {1'b1, 3'b0, 68'b0}) begin
            errors++;
            $display("FAIL midreset_values: rdy=%b busy=%b done=%b err=%b col=%h stb=%h data=%h, required rdy=1 rest 0",
                     s_ready, busy, done, err, ColSelect, FrameStrobe, FrameData);
        end
        reset = 1'b0;
        repeat (2) @(negedge UserCLK);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL midreset_strobes: got %0d strobes, required 2 (%h %h)", obs_q.size(), exp_q[0], exp_q[1]);
        end
        clear_q();
        run_block(32'hFA07_0102, 0, 1'b1);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL midreset_reload: got %0d strobes, required 2 (%h %h)", obs_q.size(), exp_q[0], exp_q[1]);
        end
    endtask

    task automatic test_random();
        logic [31:0] h;
        int d0 = done_cnt, blocks = 0;
        bit good, exp_err;
        int c, s, n, sy;
        clear_q();
        for (int it = 0; it < 25; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                c = $urandom_range(0, 15);
                n = $urandom_range(1, 4);
                s = $urandom_range(0, 20 - n);
                sy = 8'hFA;
                case ($urandom_range(0, 3))
                    0: begin sy = $urandom_range(0, 255); if (sy == 8'hFA) sy = 0; end
                    1: c = $urandom_range(16, 255);
                    2: n = 0;
                    default: begin n = $urandom_range(1, 20); s = $urandom_range(21 - n, 255); end
                endcase
                h = {8'(sy), 8'(c), 8'(s), 8'(n)};
                send(h, $urandom_range(0, 2));
                exp_err = 1'b1;
            end else begin
                n = $urandom_range(1, 8);
                s = $urandom_range(0, 20 - n);
                c = $urandom_range(0, 15);
                good = CSUM ? $urandom_range(0, 1) == 1 : 1'b1;
                run_block({8'hFA, 8'(c), 8'(s), 8'(n)}, $urandom_range(0, 2), good);
                exp_err = !good;
                blocks++;
            end
            checks++;
            if (err !== exp_err) begin
                errors++;
                $display("FAIL rand_err%0d: err=%b, required %b", it, err, exp_err);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_count: got %0d strobes, required %0d", obs_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < obs_q.size()) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_ev%0d: got %h required %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt - d0 != blocks) begin
            errors++;
            $display("FAIL rand_done: got %0d pulses, required %0d", done_cnt - d0, blocks);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (hold_bad != 0 || onehot_bad != 0 || done_col_bad != 0) begin
            errors++;
            $display("FAIL protocol: hold=%0d onehot=%0d done_col=%0d violations, required 0",
                     hold_bad, onehot_bad, done_col_bad);
        end
    endtask

`ifdef FRAME_LOADER_CHECKSUM_EN
    task automatic test_checksum();
        logic [31:0] tr [2] = '{32'hFA01_0001, 32'h0};
        int d0;
        foreach (tr[k]) begin
            d0 = done_cnt;
            send(32'hFA01_0002, 0);
            send(32'h1, 0);
            send(32'h2, 0);
            send(tr[k], 0);
            wait_idle();
            checks++;
            if (err !== (k == 1) || done_cnt - d0 != 1) begin
                errors++;
                $display("FAIL checksum%0d: err=%b done=%0d, required err=%b done=1", k, err, done_cnt - d0, k == 1);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_bad_headers();
        test_boundary();
        test_gaps();
        test_reset_mid();
        test_random();
`ifdef FRAME_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
